// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: recovery FSM encoding,
// the prediction slot carried down the pipe, and the sequential PC step.
package bru_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic        v;
    logic        pr;
    logic [31:0] ta;
  } pred_slot_t;

endpackage

// File: rtl/bru_pred_reg.sv
// One pipeline stage of prediction state (valid, taken bit, target).
// Flush has priority over stall; a flush only needs to drop the valid bit.
module bru_pred_reg
  import bru_pkg::*;
(
  input  logic       clk,
  input  logic       RESET,
  input  logic       stall,
  input  logic       flush,
  input  pred_slot_t d,
  output pred_slot_t q
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value regardless of block ordering.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      q <= '0;
    end else if (flush) begin
      q.v <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side check of fetch-time branch predictions: redirect, flush,
// predictor update strobes and saturating performance counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             StallD,
  input  logic             FlushD_in,
  input  logic             FlushE_in,
  input  logic             PrPCSrc_F,
  input  logic [31:0]      PrALUResult_F,
  input  logic             Branch_E,
  input  logic             PCSrc_E,
  input  logic [31:0]      ALUResult_E,
  input  logic [31:0]      PC_E,
  output logic             Mispredict_E,
  output logic [31:0]      RedirectPC_E,
  output logic             FlushD_BR,
  output logic             FlushE_BR,
  output logic             WE_PrPCSrc,
  output logic             WE_PrALUResult,
  output logic             PrPCSrc_E,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  pred_slot_t f_slot, d_slot, e_slot;
  bru_state_e state, state_next;
  logic       act, dir_miss, tgt_miss, alias_miss, mispredict;

  assign f_slot = '{v: 1'b1, pr: PrPCSrc_F, ta: PrALUResult_F};

  bru_pred_reg u_fd_reg (
    .clk   (clk),
    .RESET (RESET),
    .stall (StallD),
    .flush (FlushD_in | mispredict),
    .d     (f_slot),
    .q     (d_slot)
  );

  bru_pred_reg u_de_reg (
    .clk   (clk),
    .RESET (RESET),
    .stall (1'b0),
    .flush (FlushE_in | mispredict),
    .d     (d_slot),
    .q     (e_slot)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    state_next     = state;
    act            = e_slot.v && (state == IDLE);
    dir_miss       = 1'b0;
    tgt_miss       = 1'b0;
    alias_miss     = 1'b0;
    RedirectPC_E   = '0;
    WE_PrALUResult = 1'b0;

    // The RECOVER cycle holds the flushed bubble: nothing resolves there.
    if (act) begin
      dir_miss   = Branch_E && (PCSrc_E != e_slot.pr);
      tgt_miss   = Branch_E && PCSrc_E && e_slot.pr && (ALUResult_E != e_slot.ta);
      alias_miss = !Branch_E && e_slot.pr;
      RedirectPC_E   = (Branch_E && PCSrc_E) ? ALUResult_E : PC_E + PC_STEP;
      WE_PrALUResult = Branch_E && PCSrc_E && (dir_miss || tgt_miss);
    end

    mispredict = dir_miss || tgt_miss || alias_miss;

    case (state)
      IDLE:    if (mispredict) state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Mispredict_E = mispredict;
  assign FlushD_BR    = mispredict;
  assign FlushE_BR    = mispredict;
  assign WE_PrPCSrc   = dir_miss || alias_miss;
  assign PrPCSrc_E    = e_slot.v && e_slot.pr;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      if (act && Branch_E && (BranchCount != '1))
        BranchCount <= BranchCount + CNT_W'(1);
      if (mispredict && (MispredCount != '1))
        MispredCount <= MispredCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand-written corner
// sequences and randomized traffic against a pipeline-level reference model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        RESET;
  logic        StallD, FlushD_in, FlushE_in, PrPCSrc_F;
  logic [31:0] PrALUResult_F;
  logic        Branch_E, PCSrc_E;
  logic [31:0] ALUResult_E, PC_E;

  logic        Mispredict_E, FlushD_BR, FlushE_BR, WE_PrPCSrc, WE_PrALUResult, PrPCSrc_E;
  logic [31:0] RedirectPC_E, BranchCount, MispredCount;

  logic        mis_s, fd_s, fe_s, wed_s, wet_s, pr_s;
  logic [31:0] redir_s;
  logic [1:0]  BranchCount_s, MispredCount_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(32)) dut (
    .clk(clk), .RESET(RESET), .StallD(StallD), .FlushD_in(FlushD_in), .FlushE_in(FlushE_in),
    .PrPCSrc_F(PrPCSrc_F), .PrALUResult_F(PrALUResult_F), .Branch_E(Branch_E),
    .PCSrc_E(PCSrc_E), .ALUResult_E(ALUResult_E), .PC_E(PC_E),
    .Mispredict_E(Mispredict_E), .RedirectPC_E(RedirectPC_E), .FlushD_BR(FlushD_BR),
    .FlushE_BR(FlushE_BR), .WE_PrPCSrc(WE_PrPCSrc), .WE_PrALUResult(WE_PrALUResult),
    .PrPCSrc_E(PrPCSrc_E), .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  // Narrow-counter copy driven by the same stimulus, to exercise saturation.
  branch_resolve_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .RESET(RESET), .StallD(StallD), .FlushD_in(FlushD_in), .FlushE_in(FlushE_in),
    .PrPCSrc_F(PrPCSrc_F), .PrALUResult_F(PrALUResult_F), .Branch_E(Branch_E),
    .PCSrc_E(PCSrc_E), .ALUResult_E(ALUResult_E), .PC_E(PC_E),
    .Mispredict_E(mis_s), .RedirectPC_E(redir_s), .FlushD_BR(fd_s),
    .FlushE_BR(fe_s), .WE_PrPCSrc(wed_s), .WE_PrALUResult(wet_s),
    .PrPCSrc_E(pr_s), .BranchCount(BranchCount_s), .MispredCount(MispredCount_s)
  );

  // ---------------- reference model ----------------
  typedef struct { bit v; bit pr; logic [31:0] ta; } slot_t;
  typedef struct packed { logic mis; logic [31:0] redir; logic we_dir; logic we_tgt; logic br; } res_t;

  slot_t       md, me;
  bit          m_rec;
  logic [31:0] m_bc, m_mc;

  task automatic model_reset();
    md = '{0, 0, 32'h0};
    me = '{0, 0, 32'h0};
    m_rec = 0;
    m_bc = 0;
    m_mc = 0;
  endtask

  function automatic res_t model_resolve();
    res_t r = '0;
    if (me.v && !m_rec) begin
      r.redir = PC_E + 32'd4;
      if (Branch_E) begin
        r.br = 1;
        if (PCSrc_E) r.redir = ALUResult_E;
        r.we_dir = (PCSrc_E != me.pr);
        r.mis    = r.we_dir || (PCSrc_E && me.pr && ALUResult_E != me.ta);
        r.we_tgt = PCSrc_E && r.mis;
      end else begin
        r.mis    = me.pr;
        r.we_dir = me.pr;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] sat3(logic [31:0] x);
    return (x > 3) ? 32'd3 : x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    StallD = 0; FlushD_in = 0; FlushE_in = 0;
    PrPCSrc_F = 0; PrALUResult_F = 0;
    Branch_E = 0; PCSrc_E = 0; ALUResult_E = 0; PC_E = 0;
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic cycle();
    res_t  r;
    slot_t nd, ne;
    #1;
    r = model_resolve();
    check("mispredict", Mispredict_E, r.mis);
    check("flushd_br", FlushD_BR, r.mis);
    check("flushe_br", FlushE_BR, r.mis);
    check("we_prpcsrc", WE_PrPCSrc, r.we_dir);
    check("we_pralu", WE_PrALUResult, r.we_tgt);
    check("prpcsrc_e", PrPCSrc_E, me.v && me.pr);
    check("sat_mispredict", mis_s, r.mis);
    if (r.mis || m_rec) check("redirect", RedirectPC_E, r.redir);
    nd = md;
    ne = me;
    if (FlushE_in || r.mis) ne.v = 0;
    else                    ne = md;
    if (FlushD_in || r.mis) nd.v = 0;
    else if (!StallD)       nd = '{1, PrPCSrc_F, PrALUResult_F};
    @(posedge clk);
    md = nd;
    me = ne;
    m_rec = !m_rec && r.mis;
    m_bc = m_bc + 32'(r.br);
    m_mc = m_mc + 32'(r.mis);
    #1;
    check("branch_count", BranchCount, m_bc);
    check("mispred_count", MispredCount, m_mc);
    check("branch_count_sat", {30'b0, BranchCount_s}, sat3(m_bc));
    check("mispred_count_sat", {30'b0, MispredCount_s}, sat3(m_mc));
    @(negedge clk);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_mis"}, Mispredict_E, 0);
    check({tag, "_redir"}, RedirectPC_E, 0);
    check({tag, "_flush"}, {FlushD_BR, FlushE_BR}, 0);
    check({tag, "_we"}, {WE_PrPCSrc, WE_PrALUResult}, 0);
    check({tag, "_prpcsrc_e"}, PrPCSrc_E, 0);
    check({tag, "_counts"}, BranchCount | MispredCount, 0);
    check({tag, "_counts_sat"}, {28'b0, BranchCount_s, MispredCount_s}, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit pr; logic [31:0] ta;
    bit br; bit tk; bit fe; logic [31:0] alu; logic [31:0] pc;
    bit mis; logic [31:0] redir; bit we_dir; bit we_tgt; int bc_inc;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(int i, bit trailing);
    logic [31:0] bc0;
    vec_t v = vecs[i];
    idle(); PrPCSrc_F = v.pr; PrALUResult_F = v.ta;
    cycle();
    idle();
    cycle();
    idle();
    Branch_E = v.br; PCSrc_E = v.tk; FlushE_in = v.fe; ALUResult_E = v.alu; PC_E = v.pc;
    bc0 = BranchCount;
    #1;
    check($sformatf("v%0d_mis", i), Mispredict_E, v.mis);
    check($sformatf("v%0d_flush", i), {FlushD_BR, FlushE_BR}, {2{v.mis}});
    check($sformatf("v%0d_we", i), {WE_PrPCSrc, WE_PrALUResult}, {v.we_dir, v.we_tgt});
    if (v.mis) check($sformatf("v%0d_redir", i), RedirectPC_E, v.redir);
    cycle();
    check($sformatf("v%0d_bc_inc", i), BranchCount - bc0, 32'(v.bc_inc));
    if (trailing) begin
      idle();
      cycle();
    end
  endtask

  initial begin
    vecs[0] = '{1, 32'h100, 1, 1, 0, 32'h100, 32'h40,       0, 32'h0,   0, 0, 1};
    vecs[1] = '{0, 32'h0,   1, 1, 0, 32'h240, 32'h80,       1, 32'h240, 1, 1, 1};
    vecs[2] = '{1, 32'h100, 1, 1, 0, 32'h180, 32'h50,       1, 32'h180, 0, 1, 1};
    vecs[3] = '{1, 32'h200, 0, 0, 0, 32'h0,   32'hFFFFFFFC, 1, 32'h0,   1, 0, 0};
    vecs[4] = '{1, 32'h300, 1, 0, 0, 32'h0,   32'h60,       1, 32'h64,  1, 0, 1};
    vecs[5] = '{0, 32'h0,   1, 0, 0, 32'h0,   32'h70,       0, 32'h0,   0, 0, 1};
    vecs[6] = '{0, 32'h0,   0, 0, 0, 32'h0,   32'h90,       0, 32'h0,   0, 0, 0};
    vecs[7] = '{0, 32'h0,   1, 1, 1, 32'h240, 32'h80,       1, 32'h240, 1, 1, 1};

    // Reset with busy inputs: everything must read zero.
    RESET = 1;
    idle();
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h1234; PC_E = 32'h40; PrPCSrc_F = 1;
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    RESET = 0;
    model_reset();
    idle();
    cycle();

    // Five branches, two mispredicts, ending in the RECOVER cycle.
    run_vec(0, 1); run_vec(1, 1); run_vec(5, 1); run_vec(0, 1); run_vec(1, 0);
    check("pre_reset_bc", BranchCount, 5);
    check("pre_reset_mc", MispredCount, 2);
    check("pre_reset_bc_sat", {30'b0, BranchCount_s}, 3);
    Branch_E = 1; PCSrc_E = 1; ALUResult_E = 32'h300; PC_E = 32'h10;
    #2 RESET = 1;
    #1 check_zero("mid_reset");
    model_reset();
    @(negedge clk);
    RESET = 0;
    #1 check("post_reset_no_mis", Mispredict_E, 0);
    cycle();

    for (int i = 0; i < 8; i++) run_vec(i, 1);

    // Stall and flush of D in the same cycle: flush wins, nothing reaches E valid.
    idle(); PrPCSrc_F = 1; PrALUResult_F = 32'h500;
    cycle();
    StallD = 1; FlushD_in = 1; FlushE_in = 1;
    cycle();
    idle();
    cycle();
    #1 check("stall_flush_no_mis", Mispredict_E, 0);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      StallD        = ($urandom_range(3) == 0);
      FlushD_in     = ($urandom_range(15) == 0);
      FlushE_in     = ($urandom_range(15) == 0);
      PrPCSrc_F     = 1'($urandom_range(1));
      PrALUResult_F = 32'($urandom_range(15)) << 2;
      Branch_E      = ($urandom_range(3) != 0);
      PCSrc_E       = 1'($urandom_range(1));
      ALUResult_E   = ($urandom_range(1) == 1) ? me.ta : 32'($urandom_range(15)) << 2;
      PC_E          = ($urandom_range(7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
